// File: rtl/alu_unit.sv
// Single-cycle RV32I integer/branch execution unit: evaluates the dispatched op combinationally and
// registers the tagged result, plus branch/jump resolution, for one cycle on the result bus.
module alu_unit (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clr_in,
   input  logic        rs_to_alu_ready,
   input  logic [5:0]  rs_to_alu_op,
   input  logic [31:0] rs_to_alu_rs1,
   input  logic [31:0] rs_to_alu_rs2,
   input  logic [31:0] rs_to_alu_imm,
   input  logic [31:0] rs_to_alu_PC,
   input  logic [3:0]  rs_to_alu_rob_index,
   output logic        alu_ready,
   output logic [31:0] alu_result,
   output logic [3:0]  alu_rob_index,
   output logic        alu_jump,
   output logic [31:0] alu_jump_addr
);

   typedef enum logic [5:0] {
      OpAdd,  OpSub,  OpAnd,  OpOr,   OpXor,   OpSll,   OpSrl,  OpSra,
      OpSlt,  OpSltu, OpAddi, OpAndi, OpOri,   OpXori,  OpSlli, OpSrli,
      OpSrai, OpSlti, OpSltiu, OpLui, OpAuipc, OpJal,   OpJalr, OpBeq,
      OpBne,  OpBlt,  OpBge,  OpBltu, OpBgeu,  OpLb,    OpLw,   OpSw
   } op_e;

   logic [31:0] rs1, rs2, imm, opb;
   logic [31:0] pc_plus4, pc_plus_imm, jalr_sum;
   logic [4:0]  shamt;
   logic        is_imm;
   logic        taken;
   logic [31:0] res;
   logic        jump;
   logic [31:0] addr;

   logic        ready_d, ready_q;
   logic [31:0] result_d, result_q;
   logic [3:0]  rob_d, rob_q;
   logic        jump_d, jump_q;
   logic [31:0] addr_d, addr_q;

   assign rs1         = rs_to_alu_rs1;
   assign rs2         = rs_to_alu_rs2;
   assign imm         = rs_to_alu_imm;
   assign pc_plus4    = rs_to_alu_PC + 32'd4;
   assign pc_plus_imm = rs_to_alu_PC + imm;
   assign jalr_sum    = rs1 + imm;

   always_comb begin
      is_imm = rs_to_alu_op inside {OpAddi, OpAndi, OpOri, OpXori, OpSlli, OpSrli, OpSrai,
                                    OpSlti, OpSltiu};
      opb    = is_imm ? imm : rs2;
      shamt  = opb[4:0];
      res    = 32'd0;
      jump   = 1'b0;
      addr   = pc_plus4;
      taken  = 1'b0;
      case (rs_to_alu_op)
         OpAdd, OpAddi:   res = rs1 + opb;
         OpSub:           res = rs1 - rs2;
         OpAnd, OpAndi:   res = rs1 & opb;
         OpOr, OpOri:     res = rs1 | opb;
         OpXor, OpXori:   res = rs1 ^ opb;
         OpSll, OpSlli:   res = rs1 << shamt;
         OpSrl, OpSrli:   res = rs1 >> shamt;
         OpSra, OpSrai:   res = $unsigned($signed(rs1) >>> shamt);
         OpSlt, OpSlti:   res = {31'd0, $signed(rs1) < $signed(opb)};
         OpSltu, OpSltiu: res = {31'd0, rs1 < opb};
         OpLui:           res = imm;
         OpAuipc:         res = pc_plus_imm;
         OpJal: begin
            res  = pc_plus4;
            jump = 1'b1;
            addr = pc_plus_imm;
         end
         OpJalr: begin
            res  = pc_plus4;
            jump = 1'b1;
            addr = {jalr_sum[31:1], 1'b0};
         end
         OpBeq:  taken = (rs1 == rs2);
         OpBne:  taken = (rs1 != rs2);
         OpBlt:  taken = ($signed(rs1) < $signed(rs2));
         OpBge:  taken = ($signed(rs1) >= $signed(rs2));
         OpBltu: taken = (rs1 < rs2);
         OpBgeu: taken = (rs1 >= rs2);
         default: ;
      endcase
      // Branches leave res at 0; only the target depends on the outcome.
      if (taken) begin
         jump = 1'b1;
         addr = pc_plus_imm;
      end
   end

   // Idle cycles drop the valid bit but keep the stale data; rdy_in low freezes everything.
   always_comb begin
      ready_d  = ready_q;
      result_d = result_q;
      rob_d    = rob_q;
      jump_d   = jump_q;
      addr_d   = addr_q;
      if (rdy_in) begin
         ready_d = rs_to_alu_ready;
         if (rs_to_alu_ready) begin
            result_d = res;
            rob_d    = rs_to_alu_rob_index;
            jump_d   = jump;
            addr_d   = addr;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || clr_in) begin
         ready_q  <= 1'b0;
         result_q <= 32'd0;
         rob_q    <= 4'd0;
         jump_q   <= 1'b0;
         addr_q   <= 32'd0;
      end else begin
         ready_q  <= ready_d;
         result_q <= result_d;
         rob_q    <= rob_d;
         jump_q   <= jump_d;
         addr_q   <= addr_d;
      end
   end

   assign alu_ready     = ready_q;
   assign alu_result    = result_q;
   assign alu_rob_index = rob_q;
   assign alu_jump      = jump_q;
   assign alu_jump_addr = addr_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: hand-computed results, latency, stall, flush and reset.
module tb_alu_unit;

   localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_AND  = 6'd2,  OP_SLL  = 6'd5;
   localparam logic [5:0] OP_SRL  = 6'd6,  OP_SRA  = 6'd7,  OP_SLT  = 6'd8,  OP_SLTU = 6'd9;
   localparam logic [5:0] OP_ORI  = 6'd12, OP_XORI = 6'd13, OP_SLLI = 6'd14, OP_SRAI = 6'd16;
   localparam logic [5:0] OP_SLTI = 6'd17, OP_LUI  = 6'd19, OP_AUIPC = 6'd20, OP_JAL = 6'd21;
   localparam logic [5:0] OP_JALR = 6'd22, OP_BEQ  = 6'd23, OP_BNE  = 6'd24, OP_BLT  = 6'd25;
   localparam logic [5:0] OP_BGEU = 6'd28, OP_LW   = 6'd30, OP_BAD  = 6'd63;

   logic        clk = 1'b0;
   logic        rst, rdy, clr, v;
   logic [5:0]  op;
   logic [31:0] rs1, rs2, imm, pc;
   logic [3:0]  tag;
   logic        alu_ready, alu_jump;
   logic [31:0] alu_result, alu_jump_addr;
   logic [3:0]  alu_rob_index;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_unit dut (
      .clk_in              (clk),
      .rst_in              (rst),
      .rdy_in              (rdy),
      .clr_in              (clr),
      .rs_to_alu_ready     (v),
      .rs_to_alu_op        (op),
      .rs_to_alu_rs1       (rs1),
      .rs_to_alu_rs2       (rs2),
      .rs_to_alu_imm       (imm),
      .rs_to_alu_PC        (pc),
      .rs_to_alu_rob_index (tag),
      .alu_ready           (alu_ready),
      .alu_result          (alu_result),
      .alu_rob_index       (alu_rob_index),
      .alu_jump            (alu_jump),
      .alu_jump_addr       (alu_jump_addr)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
      op = o; rs1 = a; rs2 = b; imm = i; pc = p; tag = t; v = 1'b1;
   endtask

   // Dispatch one op, let it register, then check the full result bus.
   task automatic run(input string name, input logic [5:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] i, input logic [31:0] p,
                      input logic [3:0] t, input logic [31:0] e_res, input logic e_jump,
                      input logic [31:0] e_addr);
      set_op(o, a, b, i, p, t);
      tick();
      v = 1'b0;
      check({name, ".ready"}, {31'd0, alu_ready}, 32'd1);
      check({name, ".result"}, alu_result, e_res);
      check({name, ".tag"}, {28'd0, alu_rob_index}, {28'd0, t});
      check({name, ".jump"}, {31'd0, alu_jump}, {31'd0, e_jump});
      check({name, ".addr"}, alu_jump_addr, e_addr);
   endtask

   task automatic check_zero(input string name);
      check({name, ".ready"}, {31'd0, alu_ready}, 32'd0);
      check({name, ".result"}, alu_result, 32'd0);
      check({name, ".tag"}, {28'd0, alu_rob_index}, 32'd0);
      check({name, ".jump"}, {31'd0, alu_jump}, 32'd0);
      check({name, ".addr"}, alu_jump_addr, 32'd0);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; clr = 1'b0; v = 1'b0;
      op = '0; rs1 = '0; rs2 = '0; imm = '0; pc = '0; tag = '0;
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;

      run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h0, 4'd3, 32'h8000_0000, 1'b0,
          32'h4);
      tick();
      check("idle.ready", {31'd0, alu_ready}, 32'd0);

      run("sra", OP_SRA, 32'h8000_0010, 32'h24, 32'd0, 32'h10, 4'd1, 32'hF800_0001, 1'b0,
          32'h14);
      run("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0, 4'd2, 32'd1, 1'b0, 32'h4);
      run("slt", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0, 4'd2, 32'd0, 1'b0, 32'h4);
      run("sub", OP_SUB, 32'd5, 32'd7, 32'd0, 32'h0, 4'd4, 32'hFFFF_FFFE, 1'b0, 32'h4);
      run("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'h0, 4'd5, 32'h0F00_0F00, 1'b0,
          32'h4);
      run("sll", OP_SLL, 32'h3, 32'h21, 32'd0, 32'h0, 4'd5, 32'h6, 1'b0, 32'h4);
      run("srl", OP_SRL, 32'h8000_0000, 32'd31, 32'd0, 32'h0, 4'd6, 32'd1, 1'b0, 32'h4);
      run("ori", OP_ORI, 32'hF0, 32'hDEAD, 32'h0F, 32'h0, 4'd6, 32'hFF, 1'b0, 32'h4);
      run("xori", OP_XORI, 32'h0000_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h0, 4'd7, 32'hFFFF_0000,
          1'b0, 32'h4);
      run("slli", OP_SLLI, 32'd1, 32'd7, 32'h21, 32'h0, 4'd8, 32'd2, 1'b0, 32'h4);
      run("srai", OP_SRAI, 32'h8000_0000, 32'd0, 32'd31, 32'h0, 4'd8, 32'hFFFF_FFFF, 1'b0,
          32'h4);
      run("slti", OP_SLTI, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFD, 32'h0, 4'd9, 32'd1, 1'b0, 32'h4);
      run("lui", OP_LUI, 32'h1234, 32'd0, 32'hABCD_E000, 32'h8, 4'd9, 32'hABCD_E000, 1'b0,
          32'hC);
      run("auipc", OP_AUIPC, 32'd0, 32'd0, 32'h1234_5000, 32'h1000, 4'd10, 32'h1234_6000, 1'b0,
          32'h1004);
      run("blt", OP_BLT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFF8, 32'h100, 4'd11, 32'd0, 1'b1,
          32'hF8);
      run("bgeu", OP_BGEU, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFF8, 32'h100, 4'd11, 32'd0, 1'b1,
          32'hF8);
      run("beq_nt", OP_BEQ, 32'd5, 32'd6, 32'hFFFF_FFF8, 32'h100, 4'd12, 32'd0, 1'b0, 32'h104);
      run("bne_t", OP_BNE, 32'd5, 32'd6, 32'h20, 32'h100, 4'd12, 32'd0, 1'b1, 32'h120);
      run("jalr", OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd13, 32'h44, 1'b1, 32'h1002);
      run("jal", OP_JAL, 32'd0, 32'd0, 32'h10, 32'h200, 4'd13, 32'h204, 1'b1, 32'h210);
      run("lw", OP_LW, 32'h55, 32'h66, 32'h4, 32'h300, 4'd14, 32'd0, 1'b0, 32'h304);
      run("unknown", OP_BAD, 32'h55, 32'h66, 32'h4, 32'h308, 4'd15, 32'd0, 1'b0, 32'h30C);

      // Back-to-back stream with a 3-cycle freeze after the second op.
      set_op(OP_ADD, 32'd1, 32'd10, 32'd0, 32'h0, 4'd1);
      tick();
      check("s1.tag", {28'd0, alu_rob_index}, 32'd1);
      check("s1.result", alu_result, 32'd11);
      set_op(OP_ADD, 32'd2, 32'd10, 32'd0, 32'h0, 4'd2);
      tick();
      check("s2.ready", {31'd0, alu_ready}, 32'd1);
      check("s2.tag", {28'd0, alu_rob_index}, 32'd2);
      set_op(OP_ADD, 32'd3, 32'd10, 32'd0, 32'h0, 4'd3);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall.ready", {31'd0, alu_ready}, 32'd1);
         check("stall.tag", {28'd0, alu_rob_index}, 32'd2);
         check("stall.result", alu_result, 32'd12);
      end
      rdy = 1'b1;
      tick();
      check("s3.ready", {31'd0, alu_ready}, 32'd1);
      check("s3.tag", {28'd0, alu_rob_index}, 32'd3);
      check("s3.result", alu_result, 32'd13);
      set_op(OP_ADD, 32'd4, 32'd10, 32'd0, 32'h0, 4'd4);
      tick();
      v = 1'b0;
      check("s4.ready", {31'd0, alu_ready}, 32'd1);
      check("s4.tag", {28'd0, alu_rob_index}, 32'd4);
      check("s4.result", alu_result, 32'd14);
      tick();
      check("s_end.ready", {31'd0, alu_ready}, 32'd0);
      check("s_end.tag", {28'd0, alu_rob_index}, 32'd4);

      // Flush on the same edge as a dispatch of tag 7.
      run("pre_clr", OP_JAL, 32'd0, 32'd0, 32'h8, 32'h500, 4'd5, 32'h504, 1'b1, 32'h508);
      set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd7);
      clr = 1'b1;
      tick();
      clr = 1'b0; v = 1'b0;
      check_zero("clr");
      tick();
      check_zero("clr_after");

      run("pre_rst", OP_JAL, 32'd0, 32'd0, 32'h8, 32'h500, 4'd5, 32'h504, 1'b1, 32'h508);
      set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0; v = 1'b0;
      check_zero("rst");
      tick();
      check_zero("rst_after");

      // Flush wins even while frozen.
      run("pre_clr_frz", OP_JAL, 32'd0, 32'd0, 32'h8, 32'h500, 4'd5, 32'h504, 1'b1, 32'h508);
      rdy = 1'b0; clr = 1'b1;
      tick();
      rdy = 1'b1; clr = 1'b0;
      check_zero("clr_frozen");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
# alu_unit

Single-issue integer execution unit fed by the reservation station's dispatch port (`rs_to_alu_*`). It evaluates one RV32I ALU/branch/jump operation per cycle and broadcasts the result, tagged with its ROB index, on the ALU result bus (`alu_ready`/`alu_result`/`alu_rob_index`). The ROB, the RS and the LSB snoop that bus for wake-up. The unit also reports branch/jump resolution to the ROB.

## Interface
- Parameters: none. Widths come from def.v: `DATA_TYPE` and `ADDR_TYPE` are 32b, `ROB_INDEX_TYPE` and `OPENUM_TYPE` as defined there.
- Clocking and reset: one clock. Reset is synchronous and active-high.
- clk_in  in  1  clock; all state updates on posedge
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- clr_in  in  1  misprediction flush; synchronous, same priority as rst_in
- rs_to_alu_ready  in  1  dispatch valid; one op per asserted cycle, no backpressure
- rs_to_alu_op  in  `OPENUM_TYPE`  operation enum
- rs_to_alu_rs1, rs_to_alu_rs2  in  32  operand values
- rs_to_alu_imm  in  32  sign/zero-extended immediate from decode
- rs_to_alu_PC  in  32  instruction address
- rs_to_alu_rob_index  in  `ROB_INDEX_TYPE`  destination tag (nonzero)
- alu_ready  out  1  result valid, exactly one cycle per accepted op
- alu_result  out  32  rd write value
- alu_rob_index  out  `ROB_INDEX_TYPE`  tag of the result
- alu_jump  out  1  control transfer taken (branch taken, JAL, JALR)
- alu_jump_addr  out  32  target when alu_jump=1, else PC+4

## Operation
- Combinational evaluation of the registered dispatch inputs, captured into output registers at the next posedge.
- Arithmetic is 32b modulo 2^32. Carries are discarded.
- Signed compares are two's complement. `U` variants are unsigned.
- Shift amount:
  - Register shifts use rs2[4:0].
  - Immediate shifts use imm[4:0].
  - SRA/SRAI replicate bit 31.
- Register ops (ADD SUB AND OR XOR SLL SRL SRA SLT SLTU): rs1 op rs2.
- Immediate ops (ADDI ANDI ORI XORI SLLI SRLI SRAI SLTI SLTIU): rs1 op imm.
- SLT* results: 1 if true, 0 if false.
- Immediate and upper-immediate results:
  - LUI: result = imm.
  - AUIPC: result = PC+imm.
- JAL: result = PC+4, jump=1, addr = PC+imm.
- JALR: result = PC+4, jump=1, addr = (rs1+imm) & 0xFFFF_FFFE.
- BEQ BNE BLT BGE BLTU BGEU: compare rs1 and rs2, result = 0.
  - Taken: jump=1, addr = PC+imm.
  - Not taken: jump=0, addr = PC+4.
- Any other opcode (load/store/unknown): alu_ready=1, result=0, jump=0, addr=PC+4. The tag is still retired.
- Non-control ops: jump=0, addr=PC+4.
- alu_rob_index = captured rs_to_alu_rob_index, unmodified.

## Timing
- Reset/flush at posedge with rst_in|clr_in:
  - alu_ready=0, alu_result=0, alu_rob_index=0, alu_jump=0, alu_jump_addr=0.
  - A dispatch present on that edge is discarded.
- Latency:
  - RS asserts rs_to_alu_ready after posedge N.
  - The result is registered at posedge N+1.
  - alu_ready is high in the cycle after N+1.
  - Throughput is one op per cycle.
- Back-to-back dispatches produce back-to-back alu_ready pulses in the same order.
- An idle cycle (rs_to_alu_ready=0 at a posedge) loads alu_ready=0. Data outputs hold their prior values and are don't-care.
- rdy_in=0:
  - All outputs hold unchanged, including alu_ready=1 if it was set.
  - No input is sampled.
  - Consumers are frozen by the same signal, so a held pulse is not double-counted.
- Priority at a posedge: rst_in/clr_in > !rdy_in > normal update.
- clr_in with rdy_in=0 still flushes.
- No internal FSM beyond the single valid/output register stage. No multi-cycle ops.

## Test plan
- Reset, then ADD with rs1=0x7FFF_FFFF, rs2=1, tag 3 → one cycle later alu_ready=1, result=0x8000_0000, rob_index=3, jump=0. Next idle cycle alu_ready=0.
- Shifts and compares:
  - SRA rs1=0x8000_0010, rs2=0x24 → result 0xF800_0001 (shift 4).
  - SLTU 1 vs 0xFFFF_FFFF → 1.
  - SLT 1 vs 0xFFFF_FFFF → 0.
- Branches and jumps:
  - BLT rs1=-2, rs2=3, PC=0x100, imm=-8 → jump=1, addr=0xF8, result=0.
  - BGEU with the same operands → jump=1, addr=0xF8 (0xFFFF_FFFE ≥ 3 unsigned).
  - BEQ 5 vs 6 → jump=0, addr=0x104.
- JALR rs1=0x1001, imm=2, PC=0x40 → result=0x44, jump=1, addr=0x1002. AUIPC PC=0x1000, imm=0x12345000 → 0x12346000.
- Four consecutive dispatches with tags 1,2,3,4 → four consecutive alu_ready pulses with tags 1,2,3,4.
  - Insert rdy_in=0 for 3 cycles mid-stream → outputs frozen, then the sequence resumes with nothing lost or duplicated.
- clr_in asserted on the same edge as a valid dispatch (tag 7) → alu_ready=0 and all outputs 0 next cycle. Tag 7 never appears.
  - Same check with rst_in.
